// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the single data-memory port between the CPU
// load/store unit and the board debug peek path (SW[7:0] address, SW[8] enable).
// The CPU wins by default. A pending debug read takes idle slots, and it is forced
// through after STARVE_LIMIT consecutive CPU grants.
// Optional feature: define DBG_WRITE_SNOOP_EN so that a CPU store to the displayed
// word triggers a debug re-read.
module dmem_port_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int REFRESH_CYCLES = 1000000,
    parameter int STARVE_LIMIT   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_en,
    input  logic [7:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_valid,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic              pend_q, pend_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic [7:0]        iss_addr_q, iss_addr_d;
    logic              own_vld_q, own_vld_d;
    logic              own_dbg_q, own_dbg_d;
    logic              dbg_en_q, dbg_en_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
    logic              dbg_valid_q, dbg_valid_d;

    logic              gnt_cpu;
    logic              iss_dbg;
    logic              refresh_hit;
    logic              snoop_hit;
    logic              set_evt;

    // Same-cycle grant: the CPU wins unless the debug read has been starved to the limit
    always_comb begin
        gnt_cpu = 1'b0;
        iss_dbg = 1'b0;
        if (!rst) begin
            if (cpu_req && (starve_q < STARVE_MAX)) begin
                gnt_cpu = 1'b1;
            end else if (pend_q && dbg_en) begin
                iss_dbg = 1'b1;
            end
        end
    end

    // Drive the memory port from the granted requester; idle port outputs zeros
    always_comb begin
        mem_req   = gnt_cpu | iss_dbg;
        mem_we    = gnt_cpu & cpu_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt_cpu) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (iss_dbg) begin
            mem_addr = ADDR_W'({dbg_addr, 2'b00});
        end
    end

    assign cpu_gnt    = gnt_cpu;
    assign cpu_rvalid = own_vld_q & ~own_dbg_q;
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    assign dbg_rdata  = dbg_rdata_q;
    assign dbg_valid  = dbg_valid_q;

    // The periodic re-read counter runs only while the peek path is enabled
    generate
        if (REFRESH_CYCLES > 0) begin : g_refresh
            localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
            localparam logic [RW-1:0] RELOAD = RW'(REFRESH_CYCLES - 1);
            logic [RW-1:0] refresh_q, refresh_d;

            // Reload while disabled or on expiry, otherwise count down
            always_comb begin
                refresh_d = refresh_q;
                if (!dbg_en || (refresh_q == '0)) begin
                    refresh_d = RELOAD;
                end else begin
                    refresh_d = refresh_q - 1'b1;
                end
            end

            // Refresh counter register
            always_ff @(posedge clk or posedge rst) begin
                if (rst) refresh_q <= '0;
                else     refresh_q <= refresh_d;
            end

            assign refresh_hit = dbg_en && (refresh_q == '0);
        end else begin : g_no_refresh
            assign refresh_hit = 1'b0;
        end
    endgenerate

`ifdef DBG_WRITE_SNOOP_EN
    // A CPU store to the displayed word makes the display fetch it again
    assign snoop_hit = gnt_cpu && cpu_we && dbg_en &&
                       (cpu_addr[ADDR_W-1:2] == (ADDR_W-2)'(dbg_addr));
`else
    assign snoop_hit = 1'b0;
`endif

    // Next-state logic for the pending flag, starvation, issue tracking and display word
    always_comb begin
        // An address change is already served by a debug issue of that same address
        set_evt = (dbg_en & ~dbg_en_q)
                | (dbg_en & ~iss_dbg & (dbg_addr != iss_addr_q))
                | refresh_hit
                | snoop_hit;

        pend_d = pend_q;
        if (!dbg_en) begin
            pend_d = 1'b0;
        end else if (set_evt) begin
            pend_d = 1'b1;
        end else if (iss_dbg) begin
            pend_d = 1'b0;
        end

        starve_d = starve_q;
        if (iss_dbg || !pend_q) begin
            starve_d = '0;
        end else if (gnt_cpu) begin
            starve_d = starve_q + 1'b1;
        end

        iss_addr_d = iss_dbg ? dbg_addr : iss_addr_q;
        own_vld_d  = iss_dbg | (gnt_cpu & ~cpu_we);
        own_dbg_d  = iss_dbg;
        dbg_en_d   = dbg_en;

        dbg_rdata_d = dbg_rdata_q;
        dbg_valid_d = dbg_valid_q;
        if (own_vld_q && own_dbg_q) begin
            // The word is captured regardless; it is only marked valid if the switches still match
            dbg_rdata_d = mem_rdata;
            dbg_valid_d = (dbg_addr == iss_addr_q);
        end else if (dbg_en && (dbg_addr != iss_addr_q)) begin
            dbg_valid_d = 1'b0;
        end
    end

    // State registers; the asynchronous reset discards any read in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q      <= 1'b0;
            starve_q    <= '0;
            iss_addr_q  <= '0;
            own_vld_q   <= 1'b0;
            own_dbg_q   <= 1'b0;
            dbg_en_q    <= 1'b0;
            dbg_rdata_q <= '0;
            dbg_valid_q <= 1'b0;
        end else begin
            pend_q      <= pend_d;
            starve_q    <= starve_d;
            iss_addr_q  <= iss_addr_d;
            own_vld_q   <= own_vld_d;
            own_dbg_q   <= own_dbg_d;
            dbg_en_q    <= dbg_en_d;
            dbg_rdata_q <= dbg_rdata_d;
            dbg_valid_q <= dbg_valid_d;
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Testbench for dmem_port_arbiter: a behavioural synchronous memory, a table of
// CPU transactions, and hand-written sequences for the multi-cycle debug cases.
module tb_dmem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_gnt;
    logic        cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        dbg_en;
    logic [7:0]  dbg_addr;
    logic [31:0] dbg_rdata;
    logic        dbg_valid;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    dmem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .REFRESH_CYCLES(16), .STARVE_LIMIT(8)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dbg_en(dbg_en), .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata), .dbg_valid(dbg_valid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory, one-cycle read latency
    logic [31:0] mem [256];
    always @(posedge clk) begin
        if (mem_req) begin
            if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr[9:2]];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout got running expected finished");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    // CPU read returns are compared against the scoreboard
    task automatic monitor();
        logic [31:0] e;
        if (cpu_rvalid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL cpu_rvalid_unexpected got rdata %h expected no rvalid", cpu_rdata);
            end else begin
                e = exp_q.pop_front();
                chk("cpu_rdata", cpu_rdata, e);
            end
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        monitor();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        cyc();
        adv();
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_gnt"},    32'(cpu_gnt), 32'd0);
        chk({nm, "_rvalid"}, 32'(cpu_rvalid), 32'd0);
        chk({nm, "_rdata"},  cpu_rdata, 32'd0);
        chk({nm, "_dbgrd"},  dbg_rdata, 32'd0);
        chk({nm, "_dbgv"},   32'(dbg_valid), 32'd0);
        chk({nm, "_mreq"},   32'(mem_req), 32'd0);
        chk({nm, "_mwe"},    32'(mem_we), 32'd0);
        chk({nm, "_maddr"},  mem_addr, 32'd0);
        chk({nm, "_mwdata"}, mem_wdata, 32'd0);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vec[9];

    initial begin
        int n;
        int last;
        int found;

        vec[0] = '{1'b1, 32'h010, 32'hDEADBEEF, 32'h0};
        vec[1] = '{1'b1, 32'h020, 32'h12345678, 32'h0};
        vec[2] = '{1'b1, 32'h014, 32'hA5A50014, 32'h0};
        vec[3] = '{1'b0, 32'h010, 32'h00001111, 32'hDEADBEEF};
        vec[4] = '{1'b0, 32'h020, 32'h00002222, 32'h12345678};
        vec[5] = '{1'b0, 32'h014, 32'h00003333, 32'hA5A50014};
        vec[6] = '{1'b1, 32'h3FC, 32'h0F0F0F0F, 32'h0};
        vec[7] = '{1'b0, 32'h3FC, 32'h00004444, 32'h0F0F0F0F};
        vec[8] = '{1'b0, 32'h010, 32'h00005555, 32'hDEADBEEF};

        // Reset with a CPU request present: every output must stay zero
        rst = 1'b1; dbg_en = 1'b0; dbg_addr = 8'h00;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'h55AA55AA;
        adv();
        cyc();
        chk_all_zero("reset");
        adv();
        rst = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_wdata = '0;

        // CPU transactions with the debug path disabled
        for (int i = 0; i < 9; i++) begin
            cpu_req = 1'b1; cpu_we = vec[i].we; cpu_addr = vec[i].addr; cpu_wdata = vec[i].wdata;
            if (!vec[i].we) exp_q.push_back(vec[i].exp_rdata);
            cyc();
            chk($sformatf("vec%0d_gnt", i),   32'(cpu_gnt), 32'd1);
            chk($sformatf("vec%0d_mreq", i),  32'(mem_req), 32'd1);
            chk($sformatf("vec%0d_mwe", i),   32'(mem_we), 32'(vec[i].we));
            chk($sformatf("vec%0d_maddr", i), mem_addr, vec[i].addr);
            chk($sformatf("vec%0d_mwd", i),   mem_wdata, vec[i].wdata);
            adv();
        end
        cpu_req = 1'b0;
        step();
        chk("idle_dbg_rdata", dbg_rdata, 32'd0);
        chk("idle_dbg_valid", 32'(dbg_valid), 32'd0);

        // Boot peek: dbg_en already high at reset release
        rst = 1'b1; dbg_en = 1'b1; dbg_addr = 8'h04;
        step();
        step();
        rst = 1'b0;
        found = 0;
        for (int i = 0; i < 3 && found == 0; i++) begin
            cyc();
            if (mem_req) found = 1;
            else adv();
        end
        chk("boot_issue_seen", 32'(found), 32'd1);
        if (found != 0) begin
            chk("boot_maddr", mem_addr, 32'h10);
            chk("boot_mwe", 32'(mem_we), 32'd0);
            adv();
        end
        step();
        cyc();
        chk("boot_dbg_rdata", dbg_rdata, 32'hDEADBEEF);
        chk("boot_dbg_valid", 32'(dbg_valid), 32'd1);
        adv();

        // Periodic refresh with an idle CPU: one read every 16 cycles
        n = 0; last = -1;
        for (int i = 0; i < 64; i++) begin
            cyc();
            if (mem_req) begin
                n++;
                chk("refresh_maddr", mem_addr, 32'h10);
                if (last >= 0) chk("refresh_period", 32'(i - last), 32'd16);
                last = i;
            end
            adv();
        end
        chk("refresh_count", 32'(n), 32'd4);

        // dbg_en low: no debug traffic, display held
        dbg_en = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (mem_req) n++;
            adv();
        end
        chk("disabled_reads", 32'(n), 32'd0);
        chk("disabled_hold_rdata", dbg_rdata, 32'hDEADBEEF);
        chk("disabled_hold_valid", 32'(dbg_valid), 32'd1);

        // Starvation: CPU loads every cycle while a debug read is pending
        dbg_en = 1'b1; dbg_addr = 8'h08;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h20; cpu_wdata = '0;
        for (int k = 0; k < 12; k++) begin
            cyc();
            if (cpu_gnt) exp_q.push_back(32'h12345678);
            if (k >= 1) chk($sformatf("starve_gnt_%0d", k), 32'(cpu_gnt), (k == 9) ? 32'd0 : 32'd1);
            if (k == 9) begin
                chk("starve_dbg_mreq", 32'(mem_req), 32'd1);
                chk("starve_dbg_maddr", mem_addr, 32'h20);
                chk("starve_dbg_mwe", 32'(mem_we), 32'd0);
            end
            if (k == 11) begin
                chk("starve_dbg_rdata", dbg_rdata, 32'h12345678);
                chk("starve_dbg_valid", 32'(dbg_valid), 32'd1);
            end
            adv();
        end
        cpu_req = 1'b0;
        dbg_en = 1'b0;
        step();
        step();

        // Address change while a debug read is in flight
        dbg_en = 1'b1; dbg_addr = 8'h04;
        step();
        cyc();
        chk("chg_issue_mreq", 32'(mem_req), 32'd1);
        chk("chg_issue_maddr", mem_addr, 32'h10);
        chk("chg_valid_cleared", 32'(dbg_valid), 32'd0);
        adv();
        dbg_addr = 8'h05;
        cyc();
        chk("chg_return_mreq", 32'(mem_req), 32'd0);
        adv();
        cyc();
        chk("chg_stale_rdata", dbg_rdata, 32'hDEADBEEF);
        chk("chg_stale_valid", 32'(dbg_valid), 32'd0);
        chk("chg_reissue_mreq", 32'(mem_req), 32'd1);
        chk("chg_reissue_maddr", mem_addr, 32'h14);
        adv();
        step();
        cyc();
        chk("chg_new_rdata", dbg_rdata, 32'hA5A50014);
        chk("chg_new_valid", 32'(dbg_valid), 32'd1);
        adv();
        dbg_addr = 8'h04;
        step();
        cyc();
        chk("back_issue_maddr", mem_addr, 32'h10);
        adv();
        step();

        // CPU store to the displayed word
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hCAFEF00D;
        cyc();
        chk("snoop_pre_rdata", dbg_rdata, 32'hDEADBEEF);
        chk("snoop_pre_valid", 32'(dbg_valid), 32'd1);
        chk("snoop_store_gnt", 32'(cpu_gnt), 32'd1);
        chk("snoop_store_mwe", 32'(mem_we), 32'd1);
        chk("snoop_store_mwd", mem_wdata, 32'hCAFEF00D);
        adv();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_wdata = '0;
        cyc();
`ifdef DBG_WRITE_SNOOP_EN
        chk("snoop_reread_mreq", 32'(mem_req), 32'd1);
        chk("snoop_reread_maddr", mem_addr, 32'h10);
`else
        chk("nosnoop_mreq", 32'(mem_req), 32'd0);
`endif
        adv();
        cyc();
        chk("snoop_after_mreq", 32'(mem_req), 32'd0);
        adv();
        cyc();
`ifdef DBG_WRITE_SNOOP_EN
        chk("snoop_rdata", dbg_rdata, 32'hCAFEF00D);
`else
        chk("nosnoop_rdata", dbg_rdata, 32'hDEADBEEF);
`endif
        chk("snoop_valid", 32'(dbg_valid), 32'd1);
        adv();
        for (int i = 0; i < 5; i++) step();
        cyc();
        chk("refresh_after_store_rdata", dbg_rdata, 32'hCAFEF00D);
        adv();

        // Reset asserted in the return cycle of a CPU load
        dbg_en = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h20;
        cyc();
        chk("rstmid_gnt", 32'(cpu_gnt), 32'd1);
        adv();
        chk("rstmid_rvalid_before", 32'(cpu_rvalid), 32'd1);
        chk("rstmid_rdata_before", cpu_rdata, 32'h12345678);
        cpu_req = 1'b0;
        rst = 1'b1;
        #1;
        chk_all_zero("rstmid");
        cyc();
        adv();
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("post_rst_rvalid", 32'(cpu_rvalid), 32'd0);
            adv();
        end

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
